// File: rtl/muldiv_unit_pkg.sv
// Shared CPU definitions for the RV32M multiply/divide unit:
// operation encoding and the special-case divide results.
package muldiv_unit_pkg;

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } muldiv_op_t;

    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN   = 32'h8000_0000;

endpackage

// File: rtl/muldiv_unit_if.sv
// Execute-stage handshake between the pipeline (master) and the
// multiply/divide unit (slave).
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    import muldiv_unit_pkg::*;

    logic            start;
    muldiv_op_t      op;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (output start, op, A, B, flush, input busy, done, result);
    modport slave  (input start, op, A, B, flush, output busy, done, result);

endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, 32 cycles per op, sign fix-up afterwards.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_unit_if.slave bus
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state;
    muldiv_op_t        op_q;
    logic              neg_res;
    logic              neg_rem;
    logic [CW-1:0]     count;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opnd;

    logic              accept;
    logic              is_div;
    logic              sign_a;
    logic              sign_b;
    logic              div_zero;
    logic              div_ovf;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic [XLEN-1:0]   special_val;
    logic [XLEN:0]     rem_sh;
    logic [XLEN-1:0]   diff;
    logic [XLEN:0]     sum;
    logic [2*XLEN-1:0] acc_step;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   fix_val;

    // Launch decode: signs, magnitudes and the no-iteration special cases.
    always_comb begin
        accept   = (state == IDLE || state == DONE) && bus.start && !bus.flush;
        is_div   = bus.op[2];
        sign_a   = bus.A[XLEN-1] && (bus.op inside {MUL, MULH, MULHSU, DIV, REM});
        sign_b   = bus.B[XLEN-1] && (bus.op inside {MUL, MULH, DIV, REM});
        mag_a    = sign_a ? -bus.A : bus.A;
        mag_b    = sign_b ? -bus.B : bus.B;
        div_zero = is_div && (bus.B == '0);
        div_ovf  = (bus.op inside {DIV, REM}) && (bus.A == INT_MIN) && (bus.B == '1);
        // op[1] separates REM/REMU from DIV/DIVU
        if (div_zero) special_val = bus.op[1] ? bus.A : DIV0_QUOT;
        else          special_val = bus.op[1] ? '0    : INT_MIN;
    end

    // One iteration of the shared datapath; the low half of acc holds the
    // multiplier (shifted out) or the dividend/quotient (shifted through).
    always_comb begin
        rem_sh = acc[2*XLEN-1:XLEN-1];
        diff   = rem_sh[XLEN-1:0] - opnd;
        sum    = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        if (op_q[2]) begin
            if (rem_sh >= {1'b0, opnd}) acc_step = {diff, acc[XLEN-2:0], 1'b1};
            else                        acc_step = {acc[2*XLEN-2:0], 1'b0};
        end else begin
            acc_step = {sum, acc[XLEN-1:1]};
        end
    end

    always_comb begin
        prod = neg_res ? -acc : acc;
        quot = neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        case (op_q)
            MUL:                 fix_val = prod[XLEN-1:0];
            MULH, MULHSU, MULHU: fix_val = prod[2*XLEN-1:XLEN];
            DIV, DIVU:           fix_val = quot;
            default:             fix_val = rem;
        endcase
    end

    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values; blocking would chain updates within a cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            op_q       <= MUL;
            neg_res    <= 1'b0;
            neg_rem    <= 1'b0;
            count      <= '0;
            acc        <= '0;
            opnd       <= '0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.result <= '0;
        end else if (bus.flush) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        op_q    <= bus.op;
                        neg_res <= sign_a ^ sign_b;
                        neg_rem <= sign_a;
                        if (div_zero || div_ovf) begin
                            state      <= DONE;
                            bus.done   <= 1'b1;
                            bus.result <= special_val;
                        end else begin
                            state    <= CALC;
                            bus.busy <= 1'b1;
                            count    <= CW'(XLEN - 1);
                            acc      <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
                            opnd     <= is_div ? mag_b : mag_a;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    acc <= acc_step;
                    if (count == '0) state <= FIX;
                    else             count <= count - 1'b1;
                end
                FIX: begin
                    state      <= DONE;
                    bus.busy   <= 1'b0;
                    bus.done   <= 1'b1;
                    bus.result <= fix_val;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed table, randomized ops against
// an arithmetic reference model, and hand-written flush/reset/back-to-back cases.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    muldiv_unit_if #(.XLEN(32)) bus ();

    muldiv_unit #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        string       name;
        muldiv_op_t  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    function automatic bit is_special(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b);
        if ((op inside {DIV, DIVU, REM, REMU}) && b == 32'd0) return 1'b1;
        if ((op inside {DIV, REM}) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b1;
        return 1'b0;
    endfunction

    // Plain 64-bit arithmetic on the architectural definition of each op.
    function automatic logic [31:0] ref_model(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        p  = '0;
        case (op)
            MUL:    begin p = sa * sb; return p[31:0];  end
            MULH:   begin p = sa * sb; return p[63:32]; end
            MULHSU: begin p = sa * ub; return p[63:32]; end
            MULHU:  begin p = ua * ub; return p[63:32]; end
            DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            DIVU: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    // Launch one op (in the current cycle if b2b, else at the next negedge),
    // then watch busy/done/result cycle by cycle from the accept cycle.
    task automatic do_op(input string name, input muldiv_op_t op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp,
                         input int poke_at, input int flush_at, input bit b2b);
        logic [31:0] held, res;
        int          done_at, busy_err, hold_err, exp_done;
        bit          sp;
        logic        exp_busy;
        if (!b2b) @(negedge clk);
        held  = bus.result;
        sp    = is_special(op, a, b);
        bus.start = 1'b1; bus.op = op; bus.A = a; bus.B = b;
        @(negedge clk);
        bus.start = 1'b0;
        res = held; done_at = -1; busy_err = 0; hold_err = 0;
        for (int n = 1; n <= 40; n++) begin
            exp_busy = !sp && n <= 33 && (flush_at == 0 || n <= flush_at);
            if (bus.busy !== exp_busy) busy_err++;
            if (bus.done === 1'b1) begin
                done_at = n;
                res     = bus.result;
                break;
            end
            if (bus.result !== held) hold_err++;
            bus.start = (n == poke_at);
            if (n == poke_at) begin
                bus.op = MUL; bus.A = 32'd3; bus.B = 32'd3;
            end
            bus.flush = (n == flush_at);
            @(negedge clk);
        end
        bus.start = 1'b0;
        bus.flush = 1'b0;
        exp_done = (flush_at != 0) ? -1 : (sp ? 1 : 34);
        check({name, ".done_cycle"}, done_at, exp_done);
        if (flush_at == 0) check({name, ".result"}, res, exp);
        check({name, ".busy_errs"}, busy_err, 0);
        check({name, ".hold_errs"}, hold_err, 0);
    endtask

    vec_t vecs[$];

    initial begin
        muldiv_op_t  rop;
        logic [31:0] ra, rb;

        vecs = '{
            '{"mul_7_m3",      MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB},
            '{"mulh_min_min",  MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000},
            '{"mulhu_max",     MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE},
            '{"mulhsu_max",    MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF},
            '{"div_m7_2",      DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD},
            '{"rem_m7_2",      REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF},
            '{"divu_100_7",    DIVU,   32'd100,        32'd7,         32'd14},
            '{"remu_100_7",    REMU,   32'd100,        32'd7,         32'd2},
            '{"div_5_0",       DIV,    32'd5,          32'd0,         32'hFFFF_FFFF},
            '{"remu_5_0",      REMU,   32'd5,          32'd0,         32'd5},
            '{"div_ovf",       DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000},
            '{"rem_ovf",       REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0},
            '{"divu_5_0",      DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF},
            '{"rem_m7_0",      REM,    32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9},
            '{"divu_min_m1",   DIVU,   32'h8000_0000,  32'hFFFF_FFFF, 32'd0},
            '{"mul_0_x",       MUL,    32'd0,          32'h1234_5678, 32'd0}
        };

        bus.start = 1'b0; bus.flush = 1'b0; bus.op = MUL; bus.A = '0; bus.B = '0;
        repeat (2) @(negedge clk);
        check("reset.busy",   bus.busy,   1'b0);
        check("reset.done",   bus.done,   1'b0);
        check("reset.result", bus.result, 32'd0);
        rst = 1'b0;

        foreach (vecs[i])
            do_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 0, 0, 1'b0);
        @(negedge clk);
        check("done.one_cycle", bus.done, 1'b0);

        for (int i = 0; i < 40; i++) begin
            rop = muldiv_op_t'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 9) == 0) begin
                ra = 32'h8000_0000; rb = 32'hFFFF_FFFF;
            end
            if ($urandom_range(0, 3) == 0) rb = $urandom_range(1, 20);
            do_op($sformatf("rand%0d", i), rop, ra, rb, ref_model(rop, ra, rb), 0, 0, 1'b0);
        end

        // start while busy is ignored; then flush of a second op
        do_op("ignore_start", DIV, 32'd1000, 32'hFFFF_FFFD, 32'hFFFF_FEB3, 10, 0, 1'b0);
        do_op("flush_mid", MULHU, 32'hDEAD_BEEF, 32'h1234_5678, 32'd0, 0, 12, 1'b0);
        check("flush.result_kept", bus.result, 32'hFFFF_FEB3);

        // back-to-back: second launch in the DONE cycle of the first
        do_op("b2b_first",  DIVU, 32'd100, 32'd7, 32'd14, 0, 0, 1'b0);
        do_op("b2b_second", MUL,  32'd3,   32'd5, 32'd15, 0, 0, 1'b1);

        // asynchronous reset between clock edges mid-CALC
        @(negedge clk);
        bus.start = 1'b1; bus.op = MUL; bus.A = 32'h0001_2345; bus.B = 32'h777;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        check("rst.pre_busy", bus.busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("rst.async_busy",   bus.busy,   1'b0);
        check("rst.async_done",   bus.done,   1'b0);
        check("rst.async_result", bus.result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_op("post_rst_mul", MUL, 32'd3, 32'd4, 32'd12, 0, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
